// File: rtl/trace_ctrl_pkg.sv
// Shared types and default cycle schedule for the trace-window sequencer.
// The event codes let benches and wrappers log the pulse stream.
package trace_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam int DEF_OFF_CYC = 3;
  localparam int DEF_ALL_CYC = 5;
  localparam int DEF_ON_CYC  = 7;
  localparam int DEF_END_CYC = 10;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_OFF,
    EV_ALL,
    EV_FLUSH,
    EV_ON,
    EV_FINISH,
    EV_LIMIT
  } event_e;

endpackage

// File: rtl/trace_sample_counter.sv
// Saturating count of traced cycles with an optional sticky budget limit.
// hit_now_o flags the edge on which the budget is reached so tracing can stop on that same edge.
module trace_sample_counter #(
  parameter int CW    = 32,
  parameter int LIMIT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          limit_hit_o,
  output logic          hit_now_o
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] LIM     = CW'(LIMIT);

  logic [CW-1:0] count_q, count_d;
  logic          limit_hit_q, limit_hit_d;

  always_comb begin
    count_d     = count_q;
    limit_hit_d = limit_hit_q;
    if (clr_i) begin
      count_d     = '0;
      limit_hit_d = 1'b0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
      if ((LIMIT != 0) && (count_d == LIM)) begin
        limit_hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      limit_hit_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      limit_hit_q <= limit_hit_d;
    end
  end

  assign count_o     = count_q;
  assign limit_hit_o = limit_hit_q;
  assign hit_now_o   = limit_hit_d & ~limit_hit_q;

endmodule

// File: rtl/trace_window_ctrl.sv
// Cycle-driven sequencer emitting dump off/all/flush/on/finish pulses and a trace-enable level.
// All outputs are registered; the sample budget lives in trace_sample_counter.
module trace_window_ctrl
  import trace_ctrl_pkg::*;
#(
  parameter int CW      = 32,
  parameter int OFF_CYC = DEF_OFF_CYC,
  parameter int ALL_CYC = DEF_ALL_CYC,
  parameter int ON_CYC  = DEF_ON_CYC,
  parameter int END_CYC = DEF_END_CYC,
  parameter int LIMIT   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [CW-1:0] cyc,
  output logic          trace_en,
  output logic          dump_off_p,
  output logic          dump_all_p,
  output logic          dump_flush_p,
  output logic          dump_on_p,
  output logic          finish_p,
  output logic          done,
  output logic [CW-1:0] samples,
  output logic          limit_hit
);

  localparam logic [63:0]   CYC_LIMIT = (64'd1 << CW) - 64'd1;
  localparam logic [CW-1:0] CYC_ONE   = CW'(1);
  localparam logic [CW-1:0] OFF_C     = CW'(OFF_CYC);
  localparam logic [CW-1:0] ALL_C     = CW'(ALL_CYC);
  localparam logic [CW-1:0] ON_C      = CW'(ON_CYC);
  localparam logic [CW-1:0] END_C     = CW'(END_CYC);

  if (!((OFF_CYC >= 1) && (OFF_CYC < ALL_CYC) && (ALL_CYC + 1 < ON_CYC) &&
        (ON_CYC < END_CYC) && (64'(END_CYC) < CYC_LIMIT))) begin : g_param_check
    $error("trace_window_ctrl: cycle schedule parameters are out of order or exceed CW");
  end

  state_e        state_q;
  logic [CW-1:0] cyc_q;
  logic          trace_en_q, off_q, all_q, flush_q, on_q, finish_q, done_q;
  logic          limit_hit_q, hit_now, run_start;

  assign run_start = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !abort;

  trace_sample_counter #(
    .CW    (CW),
    .LIMIT (LIMIT)
  ) u_samples (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (run_start),
    .en_i        (trace_en_q),
    .count_o     (samples),
    .limit_hit_o (limit_hit_q),
    .hit_now_o   (hit_now)
  );

  // abort outranks the end-of-run and every scheduled event, and freezes cyc where it was
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      trace_en_q <= 1'b0;
      off_q      <= 1'b0;
      all_q      <= 1'b0;
      flush_q    <= 1'b0;
      on_q       <= 1'b0;
      finish_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      off_q    <= 1'b0;
      all_q    <= 1'b0;
      flush_q  <= 1'b0;
      on_q     <= 1'b0;
      finish_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (run_start) begin
            state_q    <= S_ON;
            cyc_q      <= CYC_ONE;
            trace_en_q <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_ON, S_OFF, S_FLUSH: begin
          if (abort) begin
            state_q    <= S_DONE;
            finish_q   <= 1'b1;
            done_q     <= 1'b1;
            trace_en_q <= 1'b0;
          end else begin
            cyc_q <= cyc_q + CYC_ONE;
            if (cyc_q == END_C) begin
              state_q    <= S_DONE;
              finish_q   <= 1'b1;
              done_q     <= 1'b1;
              trace_en_q <= 1'b0;
            end else begin
              case (state_q)
                S_ON: begin
                  if (cyc_q == OFF_C) begin
                    state_q    <= S_OFF;
                    off_q      <= 1'b1;
                    trace_en_q <= 1'b0;
                  end else if (hit_now) begin
                    trace_en_q <= 1'b0;
                  end
                end
                S_OFF: begin
                  if (cyc_q == ALL_C) begin
                    state_q <= S_FLUSH;
                    all_q   <= 1'b1;
                  end else if (cyc_q == ON_C) begin
                    state_q    <= S_ON;
                    on_q       <= 1'b1;
                    trace_en_q <= !limit_hit_q;
                  end
                end
                S_FLUSH: begin
                  state_q <= S_OFF;
                  flush_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
              endcase
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cyc          = cyc_q;
  assign trace_en     = trace_en_q;
  assign dump_off_p   = off_q;
  assign dump_all_p   = all_q;
  assign dump_flush_p = flush_q;
  assign dump_on_p    = on_q;
  assign finish_p     = finish_q;
  assign done         = done_q;
  assign limit_hit    = limit_hit_q;

endmodule
